// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state codes, owner
// codes, default burst geometry and the write-ack data word.
package mem_bus_arbiter_pkg;

  localparam int LINE_BEATS_DEF = 8;
  localparam int LEN_W_DEF      = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  localparam logic [31:0] WR_ACK_DATA = 32'h0000_0000;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Owner picker for the memory bus arbiter.
// Default build: fixed priority, D-cache wins a tie.
// With ARB_RR_EN defined: a tie goes to the port that did not own the bus last.
module arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic i_ic_valid,
  input  logic i_dc_valid,
`ifdef ARB_RR_EN
  input  logic i_last_owner,
`endif
  output logic o_owner
);

  // Pick the owner from the two request valids.
  always_comb begin
    o_owner = OWN_IC;
`ifdef ARB_RR_EN
    if (i_ic_valid && i_dc_valid)
      o_owner = (i_last_owner == OWN_IC) ? OWN_DC : OWN_IC;
    else if (i_dc_valid)
      o_owner = OWN_DC;
`else
    if (i_dc_valid)
      o_owner = OWN_DC;
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refills/writes.
// One transaction in flight; response beats are routed back to the owner with
// the last-beat marker generated from an internal beat counter.
// Optional build macro ARB_RR_EN: round-robin tie-break instead of dc-first.
//
// Handshake rule on every valid/ready pair: a transfer happens on a rising
// clk edge where valid and ready are both 1; the sender holds valid and
// payload stable until then, and ready may depend combinationally on valid.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LINE_BEATS = LINE_BEATS_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ic_req_valid,
  output logic             ic_req_ready,
  input  logic [31:0]      ic_req_addr,
  output logic             ic_resp_valid,
  input  logic             ic_resp_ready,
  output logic [31:0]      ic_resp_data,
  output logic             ic_resp_last,
  input  logic             dc_req_valid,
  output logic             dc_req_ready,
  input  logic [31:0]      dc_req_addr,
  input  logic             dc_req_wen,
  input  logic [31:0]      dc_req_wdata,
  output logic             dc_resp_valid,
  input  logic             dc_resp_ready,
  output logic [31:0]      dc_resp_data,
  output logic             dc_resp_last,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  output logic             mem_req_wen,
  output logic [31:0]      mem_req_wdata,
  output logic [LEN_W-1:0] mem_req_len,
  input  logic             mem_resp_valid,
  output logic             mem_resp_ready,
  input  logic [31:0]      mem_resp_data,
  output logic [1:0]       o_dbg_state
);

  localparam logic [LEN_W-1:0] READ_LEN = LEN_W'(LINE_BEATS - 1);

  logic [1:0]       r_state;
  logic             r_owner;
  logic [LEN_W-1:0] r_cnt;
  logic             r_wr;
`ifdef ARB_RR_EN
  logic             r_last_owner;
`endif

  logic w_pick;
  logic w_req_fire;
  logic w_resp_fire;
  logic w_cnt_zero;

  arb_pick u_pick (
    .i_ic_valid   (ic_req_valid),
    .i_dc_valid   (dc_req_valid),
`ifdef ARB_RR_EN
    .i_last_owner (r_last_owner),
`endif
    .o_owner      (w_pick)
  );

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_req_fire  = (r_state == ST_REQ) && mem_req_valid && mem_req_ready;
  assign w_resp_fire = (r_state == ST_RESP) && mem_resp_valid && mem_resp_ready;
  assign o_dbg_state = r_state;

  // Steer request and response channels according to state and owner.
  always_comb begin
    ic_req_ready   = 1'b0;
    dc_req_ready   = 1'b0;
    ic_resp_valid  = 1'b0;
    ic_resp_data   = '0;
    ic_resp_last   = 1'b0;
    dc_resp_valid  = 1'b0;
    dc_resp_data   = '0;
    dc_resp_last   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_wen    = 1'b0;
    mem_req_wdata  = '0;
    mem_req_len    = '0;
    mem_resp_ready = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (r_owner == OWN_DC) begin
          mem_req_valid = dc_req_valid;
          mem_req_addr  = dc_req_addr;
          mem_req_wen   = dc_req_wen;
          mem_req_wdata = dc_req_wdata;
          mem_req_len   = dc_req_wen ? '0 : READ_LEN;
          dc_req_ready  = mem_req_ready;
        end else begin
          mem_req_valid = ic_req_valid;
          mem_req_addr  = ic_req_addr;
          mem_req_len   = READ_LEN;
          ic_req_ready  = mem_req_ready;
        end
      end
      ST_RESP: begin
        if (r_owner == OWN_DC) begin
          dc_resp_valid  = mem_resp_valid;
          dc_resp_data   = r_wr ? WR_ACK_DATA : mem_resp_data;
          dc_resp_last   = w_cnt_zero;
          mem_resp_ready = dc_resp_ready;
        end else begin
          ic_resp_valid  = mem_resp_valid;
          ic_resp_data   = mem_resp_data;
          ic_resp_last   = w_cnt_zero;
          mem_resp_ready = ic_resp_ready;
        end
      end
      default: ;
    endcase
  end

  // Arbitration FSM and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_IC;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ic_req_valid || dc_req_valid) begin
            r_owner <= w_pick;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_req_fire) begin
            r_cnt   <= mem_req_len;
            r_wr    <= mem_req_wen;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_resp_fire) begin
            if (w_cnt_zero)
              r_state <= ST_IDLE;
            else
              r_cnt <= r_cnt - LEN_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_RR_EN
  // Remember who last won the bus, for the round-robin tie-break.
  always_ff @(posedge clk) begin
    if (rst)
      r_last_owner <= OWN_IC;
    else if (w_req_fire)
      r_last_owner <= r_owner;
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (LINE_BEATS=8, LEN_W=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic        ic_resp_ready;
  logic [31:0] ic_resp_data;
  logic        ic_resp_last;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [31:0] dc_req_addr;
  logic        dc_req_wen;
  logic [31:0] dc_req_wdata;
  logic        dc_resp_valid;
  logic        dc_resp_ready;
  logic [31:0] dc_resp_data;
  logic        dc_resp_last;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [7:0]  mem_req_len;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(.LINE_BEATS(8), .LEN_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ic_req_valid   (ic_req_valid),
    .ic_req_ready   (ic_req_ready),
    .ic_req_addr    (ic_req_addr),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_ready  (ic_resp_ready),
    .ic_resp_data   (ic_resp_data),
    .ic_resp_last   (ic_resp_last),
    .dc_req_valid   (dc_req_valid),
    .dc_req_ready   (dc_req_ready),
    .dc_req_addr    (dc_req_addr),
    .dc_req_wen     (dc_req_wen),
    .dc_req_wdata   (dc_req_wdata),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_ready  (dc_resp_ready),
    .dc_resp_data   (dc_resp_data),
    .dc_resp_last   (dc_resp_last),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_len    (mem_req_len),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data),
    .o_dbg_state    (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the REQ phase: optional stall cycles, then one handshake.
  // Called at the falling edge of the arbitration (IDLE) cycle.
  task automatic do_req(input bit is_dc, input logic [31:0] addr, input bit wen,
                        input logic [31:0] wdata, input logic [7:0] len,
                        input int stall, input bit drop);
    @(negedge clk);
    for (int s = 0; s < stall; s++) begin
      mem_req_ready = 1'b0;
      #1;
      check("stall_state", dbg_state, 2'd1);
      check("stall_valid", mem_req_valid, 1'b1);
      check("stall_addr", mem_req_addr, addr);
      check("stall_wen", mem_req_wen, wen);
      check("stall_len", mem_req_len, len);
      check("stall_ready", is_dc ? dc_req_ready : ic_req_ready, 1'b0);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    #1;
    check("req_state", dbg_state, 2'd1);
    check("req_valid", mem_req_valid, 1'b1);
    check("req_addr", mem_req_addr, addr);
    check("req_wen", mem_req_wen, wen);
    check("req_wdata", mem_req_wdata, wdata);
    check("req_len", mem_req_len, len);
    check("req_owner_ready", is_dc ? dc_req_ready : ic_req_ready, 1'b1);
    check("req_other_ready", is_dc ? ic_req_ready : dc_req_ready, 1'b0);
    @(negedge clk);
    if (drop) begin
      if (is_dc) dc_req_valid = 1'b0;
      else       ic_req_valid = 1'b0;
    end
    mem_req_ready = 1'b0;
    #1;
    check("resp_entry_state", dbg_state, 2'd2);
    check("resp_entry_req_valid", mem_req_valid, 1'b0);
  endtask

  // Drive n response beats of a total-beat transaction, optionally toggling
  // the owner's ready every cycle. Data for beat k is base+k.
  task automatic do_resp(input bit is_dc, input int n, input int total,
                         input logic [31:0] base, input bit toggle, input bit wr);
    int got = 0;
    int cyc = 0;
    bit rdy;
    while (got < n && cyc < 200) begin
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      if (is_dc) dc_resp_ready = rdy;
      else       ic_resp_ready = rdy;
      mem_resp_valid = 1'b1;
      mem_resp_data  = wr ? 32'hFFFF_FFFF : base + got;
      #1;
      check("resp_valid", is_dc ? dc_resp_valid : ic_resp_valid, 1'b1);
      check("resp_other_valid", is_dc ? ic_resp_valid : dc_resp_valid, 1'b0);
      check("resp_data", is_dc ? dc_resp_data : ic_resp_data, wr ? 32'h0 : base + got);
      check("resp_last", is_dc ? dc_resp_last : ic_resp_last, (got == total - 1) ? 1 : 0);
      check("mem_resp_ready", mem_resp_ready, rdy);
      check("req_ready_blocked", ic_req_ready | dc_req_ready, 1'b0);
      if (rdy) got++;
      cyc++;
      @(negedge clk);
    end
    check("resp_beats", got, n);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    ic_resp_ready  = 1'b0;
    dc_resp_ready  = 1'b0;
    if (n == total) begin
      #1;
      check("idle_after_last", dbg_state, 2'd0);
      check("idle_resp_ready", mem_resp_ready, 1'b0);
    end
  endtask

  initial begin
    bit exp_dc;
    rst = 1'b1;
    ic_req_valid = 0; ic_req_addr = 0; ic_resp_ready = 0;
    dc_req_valid = 0; dc_req_addr = 0; dc_req_wen = 0; dc_req_wdata = 0; dc_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", dbg_state, 2'd0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_resp_ready", mem_resp_ready, 1'b0);
    check("rst_ic_req_ready", ic_req_ready, 1'b0);
    check("rst_dc_req_ready", dc_req_ready, 1'b0);
    check("rst_ic_resp_valid", ic_resp_valid, 1'b0);
    check("rst_dc_resp_valid", dc_resp_valid, 1'b0);
    check("rst_mem_req_len", mem_req_len, 8'd0);
    rst = 1'b0;

    // I-cache line read on its own.
    @(negedge clk);
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1000;
    #1;
    check("arb_state", dbg_state, 2'd0);
    check("arb_mem_req_valid", mem_req_valid, 1'b0);
    check("arb_ic_req_ready", ic_req_ready, 1'b0);
    do_req(1'b0, 32'h0000_1000, 1'b0, 32'h0, 8'd7, 0, 1'b1);
    do_resp(1'b0, 8, 8, 32'hA000_0000, 1'b0, 1'b0);

    // Simultaneous requests: D-cache write first, then the waiting I-cache read.
    @(negedge clk);
    dc_req_valid = 1'b1; dc_req_addr = 32'h0000_2000; dc_req_wen = 1'b1; dc_req_wdata = 32'hDEAD_BEEF;
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3000;
    do_req(1'b1, 32'h0000_2000, 1'b1, 32'hDEAD_BEEF, 8'd0, 0, 1'b1);
    dc_req_wen = 1'b0; dc_req_wdata = 32'h0;
    do_resp(1'b1, 1, 1, 32'h0, 1'b0, 1'b1);
    do_req(1'b0, 32'h0000_3000, 1'b0, 32'h0, 8'd7, 0, 1'b1);
    do_resp(1'b0, 8, 8, 32'hB000_0000, 1'b0, 1'b0);

    // Back-pressure: owner ready toggles every cycle.
    @(negedge clk);
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_4000;
    do_req(1'b0, 32'h0000_4000, 1'b0, 32'h0, 8'd7, 0, 1'b1);
    do_resp(1'b0, 8, 8, 32'hC000_0000, 1'b1, 1'b0);

    // Memory not ready for 5 cycles in REQ.
    @(negedge clk);
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_5000;
    do_req(1'b0, 32'h0000_5000, 1'b0, 32'h0, 8'd7, 5, 1'b1);
    do_resp(1'b0, 8, 8, 32'hC100_0000, 1'b0, 1'b0);

    // Reset after beat 3 of an I-cache burst, then a fresh D-cache read.
    @(negedge clk);
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_6000;
    do_req(1'b0, 32'h0000_6000, 1'b0, 32'h0, 8'd7, 0, 1'b1);
    do_resp(1'b0, 3, 8, 32'hD000_0000, 1'b0, 1'b0);
    rst = 1'b1; mem_resp_valid = 1'b1; ic_resp_ready = 1'b1; mem_resp_data = 32'h1234_5678;
    @(negedge clk);
    #1;
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_ic_resp_valid", ic_resp_valid, 1'b0);
    check("midrst_ic_resp_last", ic_resp_last, 1'b0);
    check("midrst_mem_resp_ready", mem_resp_ready, 1'b0);
    check("midrst_mem_req_valid", mem_req_valid, 1'b0);
    check("midrst_ic_req_ready", ic_req_ready, 1'b0);
    rst = 1'b0; mem_resp_valid = 1'b0; ic_resp_ready = 1'b0; mem_resp_data = 32'h0;
    @(negedge clk);
    dc_req_valid = 1'b1; dc_req_addr = 32'h0000_7000; dc_req_wen = 1'b0;
    do_req(1'b1, 32'h0000_7000, 1'b0, 32'h0, 8'd7, 0, 1'b1);
    do_resp(1'b1, 8, 8, 32'hE000_0000, 1'b0, 1'b0);

    // Both ports continuously valid from reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_8000;
    dc_req_valid = 1'b1; dc_req_addr = 32'h0000_9000; dc_req_wen = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_dc = (k % 2 == 0);
`else
      exp_dc = 1'b1;
`endif
      do_req(exp_dc, exp_dc ? 32'h0000_9000 : 32'h0000_8000, 1'b0, 32'h0, 8'd7, 0, 1'b0);
      do_resp(exp_dc, 8, 8, 32'hF000_0000 + (k << 8), 1'b0, 1'b0);
    end
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single downstream memory port between the I-cache refill path and the D-cache refill/write path of the 5-stage RISC-V core.
- Grants one requester at a time and forwards its request to memory.
- Routes the response beats back to the owner, generating the last-beat marker from an internal beat counter.
- Sits between the two cache controllers and the memory/bus interface. One transaction in flight at most.

Parameters:
LINE_BEATS, 8, number of 32-bit beats in a read (cache-line refill) burst; legal 1..256
LEN_W, 8, width of mem_req_len; must hold LINE_BEATS-1

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ic_req_valid  input  1  I-cache read request valid
ic_req_ready  output  1  I-cache request accepted
ic_req_addr  input  32  I-cache line address (word aligned)
ic_resp_valid  output  1  I-cache response beat valid
ic_resp_ready  input  1  I-cache can take beat
ic_resp_data  output  32  I-cache response beat data
ic_resp_last  output  1  final beat of I-cache burst
dc_req_valid  input  1  D-cache request valid
dc_req_ready  output  1  D-cache request accepted
dc_req_addr  input  32  D-cache address
dc_req_wen  input  1  1 = single-beat write, 0 = line read
dc_req_wdata  input  32  write data (wen=1 only)
dc_resp_valid  output  1  D-cache response beat valid (write: one ack beat)
dc_resp_ready  input  1  D-cache can take beat
dc_resp_data  output  32  read data; 0 for write ack
dc_resp_last  output  1  final beat of D-cache transaction
mem_req_valid  output  1  request to memory valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  forwarded address
mem_req_wen  output  1  forwarded write enable
mem_req_wdata  output  32  forwarded write data
mem_req_len  output  LEN_W  beats-1 (LINE_BEATS-1 for reads, 0 for writes)
mem_resp_valid  input  1  memory response beat valid
mem_resp_ready  output  1  arbiter accepts beat
mem_resp_data  input  32  memory response data

Behaviour:
Reset and clocking:
- clk rising edge; rst synchronous, active-high.
- Reset: state IDLE, owner cleared, beat counter 0.
- All valid/ready outputs are 0 in reset and IDLE. Data, addr and len outputs are 0 in IDLE.

FSM states:
- IDLE: if either req_valid is high, choose the owner and go to REQ next cycle.
  - Fixed priority: dc beats ic when both are valid in the same cycle.
  - No request is forwarded in the arbitration cycle, so arbitration costs 1 cycle.
- REQ: mem_req_* is a pure mux of the owner's request.
  - mem_req_valid = owner req_valid.
  - owner req_ready = mem_req_ready (combinational pass-through). The non-owner's ready stays 0.
  - On handshake (valid & ready): load beat counter with mem_req_len and go to RESP.
  - Requesters must hold valid and payload stable until ready. Dropping valid in REQ is a protocol violation; the arbiter stays in REQ.
- RESP:
  - owner resp_valid = mem_resp_valid; owner resp_data = mem_resp_data; mem_resp_ready = owner resp_ready.
  - The non-owner's resp_valid stays 0.
  - Each beat handshake decrements the counter.
  - resp_last = 1 while the counter is 0.
  - Handshake with counter 0 returns to IDLE; the next arbitration happens in the following cycle.
- Write: one ack beat, data ignored; dc_resp_data forced to 0.

Boundary cases:
- Back-pressure: owner resp_ready low stalls the burst with no beat loss; the counter holds.
- Request arriving at the other port during REQ/RESP waits; no preemption.
- LINE_BEATS=1: reads behave like writes (single beat, last asserted).
- Reset mid-burst: immediate return to IDLE with the counter cleared. The memory side shares rst, so stray beats cannot follow.
- Minimum transaction: 1 (IDLE) + 1 (REQ, if ready) + LINE_BEATS cycles.

Optional Feature:
ARB_RR_EN
- Defined: round-robin tie-break. A last_owner register is updated on every REQ handshake and resets to IC. On simultaneous requests in IDLE, the port that was not last_owner wins, so dc wins the first tie after reset.
- Undefined: fixed dc-over-ic priority, and no last_owner register exists.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/REQ/RESP).
  - Owner encoding (OWN_IC/OWN_DC).
  - LINE_BEATS/LEN_W defaults.
  - Write-ack data constant (32'h0).
- One sub-module, arb_pick: combinational picker taking both valids and last_owner, returning the owner. It holds the ARB_RR_EN selection so the FSM stays policy-agnostic.

Test Plan:
- ic_req_valid alone, addr 0x1000, mem_req_ready=1, LINE_BEATS=8 -> mem_req_len=7, 8 beats to ic, ic_resp_last only on 8th, state back to IDLE 1 cycle after last.
- dc and ic valid in the same cycle (dc write addr 0x2000, data 0xDEADBEEF) -> dc forwarded first with wen=1, len=0; one ack beat with data 0 and last=1; then ic read granted.
- ic_resp_ready toggled 1/0 every cycle during an 8-beat burst -> mem_resp_ready mirrors it, all 8 data words delivered in order, no drop or duplicate.
- mem_req_ready held 0 for 5 cycles in REQ -> owner req_ready 0 for those 5 cycles, payload stable on mem_req_*, single handshake on cycle 6.
- rst asserted after beat 3 of an ic burst -> next cycle all valid/ready outputs 0, state IDLE; a fresh dc read after reset completes normally.
- ARB_RR_EN defined, both ports continuously valid -> grants alternate DC, IC, DC, IC.
